// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg
//   Shared definitions for the multiplier-sharing arbiter: default float
//   format, DW_fp_mult status bit positions, rounding-mode encodings and the
//   result-pipe stage record.
//   No ports; imported with "import fp_mult_pkg::*".
package fp_mult_pkg;

  localparam int DEF_SIG_WIDTH = 17;
  localparam int DEF_EXP_WIDTH = 6;
  localparam int W             = DEF_SIG_WIDTH + DEF_EXP_WIDTH + 1;

  // Largest supported requester count, so a stage record can hold any tag
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = $clog2(MAX_REQ);

  // DW_fp_mult status flag positions
  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // DW rounding-mode encodings
  localparam logic [2:0] RND_RNE  = 3'b000;
  localparam logic [2:0] RND_RTZ  = 3'b001;
  localparam logic [2:0] RND_RUP  = 3'b010;
  localparam logic [2:0] RND_RDN  = 3'b011;
  localparam logic [2:0] RND_RNA  = 3'b100;
  localparam logic [2:0] RND_AWAY = 3'b101;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     z;
    logic [7:0]       status;
  } stage_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// fp_mult_arbiter_if
//   Request/response bus between the compute lanes and the shared multiplier.
//   Request side : req_valid, req_a, req_b, req_rnd (packed per requester), req_ready
//   Response side: rsp_valid, rsp_tag, rsp_z, rsp_status, rsp_ready
//   Modports: slave = arbiter, master = requesters/consumer.
interface fp_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import fp_mult_pkg::*;

  localparam int TW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ*3-1:0] req_rnd;
  logic [NUM_REQ-1:0]   req_ready;

  logic                 rsp_valid;
  logic [TW-1:0]        rsp_tag;
  logic [W-1:0]         rsp_z;
  logic [7:0]           rsp_status;
  logic                 rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, req_rnd, rsp_ready,
    output req_ready, rsp_valid, rsp_tag, rsp_z, rsp_status
  );

  modport master (
    output req_valid, req_a, req_b, req_rnd, rsp_ready,
    input  req_ready, rsp_valid, rsp_tag, rsp_z, rsp_status
  );

endinterface

// File: rtl/fp_mult_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin picker.
//   req       : request vector (already masked by the caller when not granting)
//   ptr       : index searched first
//   grant     : one-hot winner (zero when no request)
//   grant_idx : binary index of the winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TW-1:0]      grant_idx
);

  logic          found;
  logic [TW-1:0] idx;

  // Walk ptr, ptr+1, ... wrapping at NUM_REQ; the first active request wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = TW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter
//   Shares one external DW_fp_mult among NUM_REQ requesters: round-robin
//   grant, registered operands, PIPE_LAT result stages, tag-routed responses.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : request/response handshake (slave modport)
//   mul_a/b/rnd: registered operands to DW_fp_mult
//   mul_z/status: combinational result from DW_fp_mult
//   inflight   : ops accepted but not yet consumed
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int SIG_WIDTH = DEF_SIG_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int NUM_REQ   = 4,
  parameter int PIPE_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fp_mult_arbiter_if.slave             bus,
  output logic [SIG_WIDTH+EXP_WIDTH:0] mul_a,
  output logic [SIG_WIDTH+EXP_WIDTH:0] mul_b,
  output logic [2:0]                   mul_rnd,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] mul_z,
  input  logic [7:0]                   mul_status,
  output logic [$clog2(NUM_REQ)+1:0]   inflight
);

  localparam int TW = $clog2(NUM_REQ);

  logic               run;
  logic               stall;
  logic               accept;
  logic               consume;
  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]      grant_idx;
  logic [TW-1:0]      ptr;
  logic [TW-1:0]      op_tag;
  logic               v0;
  stage_t             pipe [PIPE_LAT];

  // A blocked response freezes every register in the block
  assign stall   = pipe[PIPE_LAT-1].valid & ~bus.rsp_ready;
  assign consume = pipe[PIPE_LAT-1].valid & bus.rsp_ready;

  // Granting is held off until one edge after reset release
  rr_arbiter #(.NUM_REQ(NUM_REQ), .TW(TW)) u_rr (
    .req       (bus.req_valid & {NUM_REQ{run & ~stall}}),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;

  // Run flag: goes high on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Operand stage and round-robin pointer; the winner's index becomes the tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_rnd <= '0;
      op_tag  <= '0;
      v0      <= 1'b0;
      ptr     <= '0;
    end else if (!stall) begin
      if (accept) begin
        mul_a   <= bus.req_a[grant_idx*W +: W];
        mul_b   <= bus.req_b[grant_idx*W +: W];
        mul_rnd <= bus.req_rnd[grant_idx*3 +: 3];
        op_tag  <= grant_idx;
        v0      <= 1'b1;
        ptr     <= (grant_idx == TW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        v0 <= 1'b0;
      end
    end
  end

  // Result pipe: bubbles shift like real entries so latency stays fixed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
    end else if (!stall) begin
      pipe[0] <= '{valid: v0, tag: TAG_W'(op_tag), z: mul_z, status: mul_status};
      for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Outstanding-op counter; simultaneous accept and consume cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (accept && !consume) begin
      inflight <= inflight + 1'b1;
    end else if (!accept && consume) begin
      inflight <= inflight - 1'b1;
    end
  end

  assign bus.rsp_valid  = pipe[PIPE_LAT-1].valid;
  assign bus.rsp_tag    = TW'(pipe[PIPE_LAT-1].tag);
  assign bus.rsp_z      = pipe[PIPE_LAT-1].z;
  assign bus.rsp_status = pipe[PIPE_LAT-1].status;

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one DW_fp_mult instance (sig_width=17, exp_width=6, 24-bit operands) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake, operand/rnd registering, PIPE_LAT-deep result pipeline, tag-routed responses.
- Sits between the vector/compute lanes and the single multiplier; a global response stall freezes the pipe.

Parameters:
SIG_WIDTH, 17, significand bits of multiplier format
EXP_WIDTH, 6, exponent bits of multiplier format
NUM_REQ, 4, number of requesters (2..8)
PIPE_LAT, 2, result register stages after multiplier (>=1)
Derived: W = SIG_WIDTH+EXP_WIDTH+1; TW = clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  NUM_REQ*W  packed operand A, requester i at [i*W +: W]
req_b  in  NUM_REQ*W  packed operand B
req_rnd  in  NUM_REQ*3  packed rounding mode
req_ready  out  NUM_REQ  one-hot grant/accept
mul_a  out  W  to DW_fp_mult a (registered)
mul_b  out  W  to DW_fp_mult b (registered)
mul_rnd  out  3  to DW_fp_mult rnd (registered)
mul_z  in  W  from DW_fp_mult z (combinational)
mul_status  in  8  from DW_fp_mult status
rsp_valid  out  1  result valid
rsp_tag  out  TW  index of originating requester
rsp_z  out  W  product
rsp_status  out  8  DW status flags
rsp_ready  in  1  downstream accepts result
inflight  out  TW+2  ops accepted but not yet consumed

Behaviour:
- Reset (async, rst_n=0): req_ready=0, mul_a/mul_b=0, mul_rnd=0, rsp_valid=0, rsp_tag=0, rsp_z=0, rsp_status=0, inflight=0, all stage valids 0, rr pointer=0. Release is synchronous to clk; first grant possible the cycle after release.
- stall = rsp_valid & ~rsp_ready. When stall: req_ready=0, every register holds (operand stage, all result stages, outputs).
- Grant (combinational, when ~stall): scan from ptr, ptr+1, ... mod NUM_REQ; first i with req_valid[i] gets req_ready[i]=1. At most one bit set. req_ready may depend on req_valid; requesters must not depend on req_ready to raise valid.
- Accept at edge where req_valid[i]&req_ready[i]:
  - operand stage loads a_i, b_i, rnd_i, tag=i, v0=1;
  - ptr <= (i+1) mod NUM_REQ.
  - No accept and ~stall: v0 <= 0, operand regs hold value, ptr holds.
- Result pipe: stage1 captures {v0, tag, mul_z, mul_status}; stages 2..PIPE_LAT shift; last stage drives rsp_* directly.
- Latency: accept edge t -> rsp_valid high after edge t+PIPE_LAT absent stalls. Throughput: 1 op/cycle.
- Bubbles advance: a stage with v=0 still shifts when ~stall (no bubble collapsing).
- Response consumed on edge with rsp_valid&rsp_ready.
- inflight: +1 on accept, -1 on consume, both same edge -> unchanged. Max PIPE_LAT+1; width must hold it.
- Payload regs of invalid stages are don't-care for the bench except reset values above.
- Reset mid-operation: all in-flight ops discarded, no rsp_valid after release.

Decomposition:
- Package fp_mult_pkg: SIG_WIDTH/EXP_WIDTH defaults, W, 8-bit status bit positions (zero=0, inf=1, invalid=2, tiny=3, huge=4, inexact=5), rnd encodings (RNE=3'b000), stage struct {valid, tag, z, status}.
- One sub-module: rr_arbiter (NUM_REQ; in req, ptr; out one-hot grant, grant index).
- DW_fp_mult stays outside; the bench instantiates it and wires mul_* ports.

Test Plan:
- Single op: req0 a=0x3E0000 (1.0), b=0x400000 (2.0), rnd=0 -> rsp_valid at t+2 (PIPE_LAT=2), tag=0, z=0x400000, status[5]=0.
- All 4 requesters valid continuously, a=0x3F0000, b=0x3F0000 -> grants 0,1,2,3,0,... one per cycle; z=0x404000 (2.25); tags follow the same order.
- Stall: hold rsp_ready=0 for 3 cycles with 3 ops in flight -> req_ready=0, rsp_* stable, inflight=3; release -> results drain in order, none lost or duplicated.
- Zero/sign: a=0x000000, b=0xBE0000 (-1.0) -> z is signed zero per DW, status[0]=1; a=0xBE0000, b=0x3E0000 -> z=0xBE0000.
- Fairness: req1 and req3 always valid, ptr starts at 0 -> grant sequence 1,3,1,3; req2 raised mid-stream gets a grant within 2 cycles.
- Async reset asserted with 2 ops in flight -> all outputs 0 immediately; after release, rsp_valid stays 0 until a new accept; first grant goes to req0 if valid.
